// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the request/ack instruction bus and presents if_pc/if_inst.
// Optional macro IF_MISALIGN_EXC_EN adds the if_misalign port and the MIS state for misaligned redirects.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_address_i,
   output logic [31:0] ibus_addr_o,
   output logic        ibus_req_o,
   input  logic        ibus_ack_i,
   input  logic [31:0] ibus_data_i,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        stallreq_from_if
`ifdef IF_MISALIGN_EXC_EN
   ,
   output logic        if_misalign
`endif
);

   localparam logic NO_STOP = 1'b0;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLD
`ifdef IF_MISALIGN_EXC_EN
      , MIS
`endif
   } state_t;

   state_t      state, state_nx;
   logic [31:0] pc_q, pc_nx;
   logic [31:0] inst_buf, inst_buf_nx;
   logic [31:0] br_tgt, br_tgt_nx;
   logic        br_pend, br_pend_nx;
   logic        consume, advance, redirect;
   logic [31:0] target;
   logic        unused_stall;

   assign unused_stall = ^{stall[5:2], stall[0]};

   function automatic logic [31:0] fix_pc(input logic [31:0] pc);
`ifdef IF_MISALIGN_EXC_EN
      return pc;
`else
      return {pc[31:2], 2'b00};
`endif
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pc_q     <= RESET_PC;
         inst_buf <= 32'h0;
         br_pend  <= 1'b0;
         br_tgt   <= 32'h0;
      end else begin
         state    <= state_nx;
         pc_q     <= pc_nx;
         inst_buf <= inst_buf_nx;
         br_pend  <= br_pend_nx;
         br_tgt   <= br_tgt_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      pc_nx       = pc_q;
      inst_buf_nx = inst_buf;
      br_pend_nx  = br_pend;
      br_tgt_nx   = br_tgt;

      consume  = (stall[1] == NO_STOP) &&
                 (((state == REQ) && ibus_ack_i) || (state == HOLD));
      redirect = branch_flag_i || br_pend;
      // A live branch flag takes priority over an older latched redirect.
      target   = branch_flag_i ? branch_target_address_i :
                 br_pend       ? br_tgt : pc_q + 32'd4;
      advance  = consume;
`ifdef IF_MISALIGN_EXC_EN
      if ((state == MIS) && (stall[1] == NO_STOP) && redirect)
         advance = 1'b1;
`endif

      if (advance) begin
         pc_nx      = fix_pc(target);
         br_pend_nx = 1'b0;
         state_nx   = REQ;
`ifdef IF_MISALIGN_EXC_EN
         if (pc_nx[1:0] != 2'b00)
            state_nx = MIS;
`endif
      end else begin
         if (branch_flag_i) begin
            br_pend_nx = 1'b1;
            br_tgt_nx  = branch_target_address_i;
         end
         case (state)
            IDLE: state_nx = REQ;
            REQ: begin
               if (ibus_ack_i) begin
                  inst_buf_nx = ibus_data_i;
                  state_nx    = HOLD;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      ibus_addr_o      = pc_q;
      if_pc            = pc_q;
      ibus_req_o       = (state == REQ);
      stallreq_from_if = (state == REQ) && !ibus_ack_i;
      if ((state == REQ) && ibus_ack_i)
         if_inst = ibus_data_i;
      else if (state == HOLD)
         if_inst = inst_buf;
      else
         if_inst = 32'h0;
`ifdef IF_MISALIGN_EXC_EN
      if_misalign = (state == MIS);
`endif
   end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a program-order fetch model predicts each cycle and each delivered instruction.
// Directed scenarios run first, then randomized stall/branch/ack/reset traffic.
module tb_if_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stall = 6'b0;
   logic        branch_flag_i = 1'b0;
   logic [31:0] branch_target_address_i = 32'h0;
   logic [31:0] ibus_addr_o;
   logic        ibus_req_o;
   logic        ibus_ack_i = 1'b0;
   logic [31:0] ibus_data_i = 32'h0;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        stallreq_from_if;
`ifdef IF_MISALIGN_EXC_EN
   logic        if_misalign;
`endif

   if_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .branch_flag_i(branch_flag_i), .branch_target_address_i(branch_target_address_i),
      .ibus_addr_o(ibus_addr_o), .ibus_req_o(ibus_req_o),
      .ibus_ack_i(ibus_ack_i), .ibus_data_i(ibus_data_i),
      .if_pc(if_pc), .if_inst(if_inst), .stallreq_from_if(stallreq_from_if)
`ifdef IF_MISALIGN_EXC_EN
      , .if_misalign(if_misalign)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit done = 1'b0;

   typedef struct packed {
      logic        req;
      logic [31:0] pc;
      logic        stallreq;
      logic [31:0] inst;
      logic        mis;
   } cyc_t;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } del_t;
   cyc_t cyc_q[$];
   del_t del_q[$];

   // Reference model: where the program counter is and what the fetch stage is holding.
   bit          m_idle = 1'b1;
   bit          m_held = 1'b0;
   bit          m_mis  = 1'b0;
   bit          m_rv   = 1'b0;
   logic [31:0] m_rt   = 32'h0;
   logic [31:0] m_pc   = RESET_PC;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h5A5A_0001;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic step(input bit r, input bit s1, input bit br,
                       input logic [31:0] tgt, input bit ack_en);
      bit          req, ack, deliver, adv;
      logic [31:0] nxt, rnd;
      cyc_t        c;
      @(negedge clk);
      req = !m_idle && !m_held && !m_mis;
      ack = req && ack_en;
      rnd = $urandom;
      rst = r;
      stall = {rnd[5:2], s1, rnd[0]};
      branch_flag_i = br;
      branch_target_address_i = br ? tgt : $urandom;
      ibus_ack_i = ack;
      ibus_data_i = ack ? mem(m_pc) : $urandom;
      if (r) begin
         m_idle = 1'b1; m_held = 1'b0; m_mis = 1'b0;
         m_rv = 1'b0; m_rt = 32'h0; m_pc = RESET_PC;
         return;
      end
      deliver    = !s1 && ((req && ack) || m_held);
      c.req      = req;
      c.pc       = m_pc;
      c.stallreq = req && !ack;
      c.inst     = ((req && ack) || m_held) ? mem(m_pc) : 32'h0;
      c.mis      = m_mis;
      cyc_q.push_back(c);
      if (deliver) del_q.push_back({m_pc, mem(m_pc)});
      adv = deliver || (m_mis && !s1 && (br || m_rv));
      if (adv) begin
         nxt = br ? tgt : m_rv ? m_rt : m_pc + 32'd4;
         m_rv = 1'b0;
         m_held = 1'b0;
`ifdef IF_MISALIGN_EXC_EN
         m_mis = (nxt[1:0] != 2'b00);
`else
         nxt[1:0] = 2'b00;
`endif
         m_pc = nxt;
      end else begin
         if (br) begin m_rv = 1'b1; m_rt = tgt; end
         if (req && ack && s1) m_held = 1'b1;
      end
      m_idle = 1'b0;
   endtask

   initial begin : monitor
      cyc_t c;
      del_t d;
      forever begin
         @(negedge clk);
         #3;
         if (done) break;
         if (rst !== 1'b0) continue;
         if (cyc_q.size() == 0) begin
            chk("cycle_queue_underflow", 32'(cyc_q.size()), 32'd1);
            continue;
         end
         c = cyc_q.pop_front();
         chk("ibus_req_o", 32'(ibus_req_o), 32'(c.req));
         chk("if_pc", if_pc, c.pc);
         if (c.req) chk("ibus_addr_o", ibus_addr_o, c.pc);
         chk("stallreq_from_if", 32'(stallreq_from_if), 32'(c.stallreq));
         chk("if_inst", if_inst, c.inst);
`ifdef IF_MISALIGN_EXC_EN
         chk("if_misalign", 32'(if_misalign), 32'(c.mis));
`endif
         if (!stall[1] && if_inst != 32'h0) begin
            if (del_q.size() == 0) begin
               chk("unexpected_delivery", if_pc, 32'hFFFF_FFFF);
            end else begin
               d = del_q.pop_front();
               chk("deliver_pc", if_pc, d.pc);
               chk("deliver_inst", if_inst, d.inst);
            end
         end
      end
   end

   initial begin : stimulus
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      // Zero-wait streaming
      step(0, 0, 0, 0, 1);
      repeat (4) step(0, 0, 0, 0, 1);
      // Slow memory
      repeat (3) step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      // Ack while IF/ID is held, then release
      step(0, 1, 0, 0, 1);
      step(0, 1, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      // Branch on the delivery cycle: delay slot then target
      step(0, 0, 1, 32'h0000_0100, 1);
      step(0, 0, 0, 0, 1);
      // Branch while waiting for ack, repeated flag
      step(0, 0, 1, 32'h0000_0200, 0);
      step(0, 0, 1, 32'h0000_0200, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      // Live flag beats a latched redirect
      step(0, 0, 1, 32'h0000_0300, 0);
      step(0, 0, 1, 32'h0000_0400, 1);
      step(0, 0, 0, 0, 1);
      // 32-bit wrap of the sequential PC
      step(0, 0, 1, 32'hFFFF_FFFC, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      // Misaligned redirect
      step(0, 0, 1, 32'h0000_0102, 1);
      step(0, 0, 0, 0, 1);
      step(0, 1, 1, 32'h0000_0040, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      // Reset while an ack arrives
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] t;
         t = {20'h0, 10'($urandom), 2'b00};
         if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
         step($urandom_range(0, 299) == 0,
              $urandom_range(0, 9) < 3,
              $urandom_range(0, 99) < 15,
              t,
              $urandom_range(0, 9) < 6);
      end
      @(posedge clk);
      #1;
      done = 1'b1;
      @(negedge clk);
      #4;
      chk("leftover_deliveries", 32'(del_q.size()), 32'd0);
      chk("leftover_cycles", 32'(cyc_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
